nand_page_buffer_mb: RTL and testbench

Parametrised multi-bank page buffer between the host-side data path and the NAND flash interface of the controller. The host streams write words into a free bank. A bank is committed when it holds a full page, or earlier on an explicit short commit. The flash side then drains committed banks in commit order. With NUM_BANKS ≥ 2, one page can fill while another drains, which the single-page buffer cannot do.

---
 rtl/nand_page_buffer_mb.sv | 199 +++++++++++++++++++
 tb/tb_nand_page_buffer_mb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_page_buffer_mb.sv
// nand_page_buffer_mb
//   Multi-bank page buffer between the host write stream and the NAND flash
//   read side. Host words fill a free bank; a bank is committed on a full page
//   or on an explicit short commit. Committed banks drain in commit order
//   through a 1-cycle registered RAM read followed by a 2-entry output skid.
//
// Ports
//   clock, reset            : single rising-edge clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data : host word handshake
//   wr_commit               : commit the filling bank as a short page
//   rd_valid/rd_ready/rd_data : flash-side word handshake
//   rd_last, rd_len         : last-word marker and length of the page being drained
//   full_banks              : committed banks not yet fully drained
//   empty                   : every bank free, no fill in progress
module nand_page_buffer_mb #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PAGE_WORDS = 2048,
    parameter int unsigned NUM_BANKS  = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            wr_commit,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_last,
    output logic [$clog2(PAGE_WORDS+1)-1:0] rd_len,
    output logic [$clog2(NUM_BANKS+1)-1:0]  full_banks,
    output logic                            empty
);

    localparam int unsigned LW    = $clog2(PAGE_WORDS + 1);
    localparam int unsigned FW    = $clog2(NUM_BANKS + 1);
    localparam int unsigned BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned DEPTH = NUM_BANKS * PAGE_WORDS;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(NUM_BANKS - 1)) ? '0 : b + BW'(1);
    endfunction

    function automatic logic [AW-1:0] bank_addr(input logic [BW-1:0] b, input logic [LW-1:0] idx);
        return AW'(b) * AW'(PAGE_WORDS) + AW'(idx);
    endfunction

    bank_state_t       bank_st  [NUM_BANKS];
    logic [LW-1:0]     bank_len [NUM_BANKS];
    logic [DATA_W-1:0] mem      [DEPTH];

    // wr_ptr: bank being filled; iss_ptr/iss_idx: next RAM read to issue;
    // rd_ptr: bank whose words are currently leaving the output stage.
    logic [BW-1:0]     wr_ptr, iss_ptr, rd_ptr;
    logic [LW-1:0]     fill_cnt, iss_idx;

    logic              q_valid, q_last;
    logic [DATA_W-1:0] q_data;
    logic [LW-1:0]     q_len;

    logic              skid_valid, skid_last;
    logic [DATA_W-1:0] skid_data;
    logic [LW-1:0]     skid_len;

    logic              wr_acc, commit, pop, drain_done, issue, iss_bank_ok, iss_last;
    logic [LW-1:0]     fill_next;
    logic [1:0]        occ_after_pop;
    logic [AW-1:0]     wr_addr, iss_addr;
    bank_state_t       iss_st;

    assign wr_ready   = (bank_st[wr_ptr] == BANK_FREE || bank_st[wr_ptr] == BANK_FILLING) && !reset;
    assign wr_acc     = wr_valid && wr_ready;
    assign fill_next  = fill_cnt + LW'(wr_acc);
    assign commit     = wr_ready &&
                        ((wr_acc && fill_cnt == LW'(PAGE_WORDS - 1)) ||
                         (wr_commit && fill_next != '0));
    assign wr_addr    = bank_addr(wr_ptr, fill_cnt);

    assign pop        = rd_valid && rd_ready;
    assign drain_done = pop && rd_last;

    // A DRAINING bank at iss_ptr with iss_idx == 0 has already been fully
    // issued and is only waiting for its tail to leave the output stage.
    assign iss_st      = bank_st[iss_ptr];
    assign iss_bank_ok = (iss_st == BANK_FULL) || (iss_st == BANK_DRAINING && iss_idx != '0);
    assign iss_last    = (iss_idx == bank_len[iss_ptr] - LW'(1));
    assign iss_addr    = bank_addr(iss_ptr, iss_idx);

    // Output stage + skid + in-flight RAM read never hold more than two words.
    assign occ_after_pop = 2'(rd_valid) + 2'(skid_valid) + 2'(q_valid) - 2'(pop);
    assign issue         = iss_bank_ok && (occ_after_pop < 2'd2);

    always_comb begin
        empty = 1'b1;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (bank_st[i] != BANK_FREE) empty = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_addr] <= wr_data;
        if (issue)  q_data       <= mem[iss_addr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                bank_st[i]  <= BANK_FREE;
                bank_len[i] <= '0;
            end
            wr_ptr     <= '0;
            iss_ptr    <= '0;
            rd_ptr     <= '0;
            fill_cnt   <= '0;
            iss_idx    <= '0;
            q_valid    <= 1'b0;
            q_last     <= 1'b0;
            q_len      <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            skid_len   <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            rd_len     <= '0;
            full_banks <= '0;
        end else begin
            // Fill side
            if (commit) begin
                fill_cnt         <= '0;
                bank_len[wr_ptr] <= fill_next;
                bank_st[wr_ptr]  <= BANK_FULL;
                wr_ptr           <= next_bank(wr_ptr);
            end else if (wr_acc) begin
                fill_cnt <= fill_next;
                if (bank_st[wr_ptr] == BANK_FREE) bank_st[wr_ptr] <= BANK_FILLING;
            end

            // RAM read issue
            q_valid <= issue;
            if (issue) begin
                if (iss_st == BANK_FULL) bank_st[iss_ptr] <= BANK_DRAINING;
                q_last <= iss_last;
                q_len  <= bank_len[iss_ptr];
                if (iss_last) begin
                    iss_idx <= '0;
                    iss_ptr <= next_bank(iss_ptr);
                end else begin
                    iss_idx <= iss_idx + LW'(1);
                end
            end

            // Bank release once its final word is taken
            if (drain_done) begin
                bank_st[rd_ptr] <= BANK_FREE;
                rd_ptr          <= next_bank(rd_ptr);
            end

            if (commit && !drain_done)      full_banks <= full_banks + FW'(1);
            else if (!commit && drain_done) full_banks <= full_banks - FW'(1);

            // Output register with skid; the in-flight RAM word always has a slot.
            if (!rd_valid || rd_ready) begin
                if (skid_valid) begin
                    rd_valid   <= 1'b1;
                    rd_data    <= skid_data;
                    rd_last    <= skid_last;
                    rd_len     <= skid_len;
                    skid_valid <= q_valid;
                    skid_data  <= q_data;
                    skid_last  <= q_last;
                    skid_len   <= q_len;
                end else begin
                    rd_valid <= q_valid;
                    if (q_valid) begin
                        rd_data <= q_data;
                        rd_last <= q_last;
                        rd_len  <= q_len;
                    end
                end
            end else if (q_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= q_data;
                skid_last  <= q_last;
                skid_len   <= q_len;
            end
        end
    end

endmodule

// File: tb/tb_nand_page_buffer_mb.sv
// Testbench for nand_page_buffer_mb: a two-bank instance (dut) and a
// single-bank instance (dut_one), both with 8-word pages.
module tb_nand_page_buffer_mb;

    localparam int DW = 16;
    localparam int PW = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          wr_valid, wr_ready, wr_commit, rd_valid, rd_ready, rd_last, empty;
    logic [DW-1:0] wr_data, rd_data;
    logic [3:0]    rd_len;
    logic [1:0]    full_banks;

    logic          b_wr_valid, b_wr_ready, b_wr_commit, b_rd_valid, b_rd_ready, b_rd_last, b_empty;
    logic [DW-1:0] b_wr_data, b_rd_data;
    logic [3:0]    b_rd_len;
    logic [0:0]    b_full_banks;

    int n_pass  = 0;
    int n_total = 0;

    nand_page_buffer_mb #(.DATA_W(DW), .PAGE_WORDS(PW), .NUM_BANKS(2)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_commit(wr_commit),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .rd_len(rd_len), .full_banks(full_banks), .empty(empty)
    );

    nand_page_buffer_mb #(.DATA_W(DW), .PAGE_WORDS(PW), .NUM_BANKS(1)) dut_one (
        .clock(clock), .reset(reset),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data), .wr_commit(b_wr_commit),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_last(b_rd_last),
        .rd_len(b_rd_len), .full_banks(b_full_banks), .empty(b_empty)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_total++;
        if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready_in_reset: got %b want 0", wr_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready_after: got %b want 1", wr_ready); else n_pass++;
        n_total++;
        if (empty !== 1'b1 || full_banks !== 2'd0) $display("FAIL reset_status: empty=%b full_banks=%0d want 1/0", empty, full_banks); else n_pass++;
        n_total++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0 || rd_last !== 1'b0 || rd_len !== 4'd0)
            $display("FAIL reset_rd_outputs: valid=%b data=%h last=%b len=%0d want 0/0000/0/0", rd_valid, rd_data, rd_last, rd_len);
        else n_pass++;

        // Partially fill, then reset in the middle of the fill.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'h0E00 + 16'(i);
            tick();
        end
        wr_valid = 1'b0;
        n_total++;
        if (empty !== 1'b0) $display("FAIL midfill_empty: got %b want 0", empty); else n_pass++;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (empty !== 1'b1 || full_banks !== 2'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL midfill_reset_status: empty=%b full=%0d rd_valid=%b wr_ready=%b want 1/0/0/1", empty, full_banks, rd_valid, wr_ready);
        else n_pass++;

        // A fresh page must start at word 0 and hold exactly these 8 words.
        rd_ready = 1'b1;
        for (int i = 0; i < PW; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'h5000 + 16'(i);
            tick();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 6 && rd_valid !== 1'b1; k++) tick();
        for (int i = 0; i < PW; i++) begin
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h5000 + 16'(i) || rd_last !== (i == PW - 1) || rd_len !== 4'd8)
                $display("FAIL post_reset_page[%0d]: valid=%b data=%h last=%b len=%0d want 1/%h/%b/8",
                         i, rd_valid, rd_data, rd_last, rd_len, 16'h5000 + 16'(i), (i == PW - 1));
            else n_pass++;
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_single_page();
        rd_ready = 1'b1;
        for (int i = 0; i < PW; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'h1000 + 16'(i);
            tick();
        end
        wr_valid = 1'b0;
        // Now just after the commit edge T.
        n_total++;
        if (full_banks !== 2'd1 || empty !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL single_after_commit: full=%0d empty=%b rd_valid=%b want 1/0/0", full_banks, empty, rd_valid);
        else n_pass++;
        tick();
        n_total++;
        if (rd_valid !== 1'b0) $display("FAIL single_latency_t1: rd_valid=%b want 0", rd_valid); else n_pass++;
        tick();
        for (int i = 0; i < PW; i++) begin
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h1000 + 16'(i) || rd_last !== (i == PW - 1) || rd_len !== 4'd8)
                $display("FAIL single_word[%0d]: valid=%b data=%h last=%b len=%0d want 1/%h/%b/8",
                         i, rd_valid, rd_data, rd_last, rd_len, 16'h1000 + 16'(i), (i == PW - 1));
            else n_pass++;
            tick();
        end
        n_total++;
        if (empty !== 1'b1 || full_banks !== 2'd0 || rd_valid !== 1'b0)
            $display("FAIL single_done: empty=%b full=%0d rd_valid=%b want 1/0/0", empty, full_banks, rd_valid);
        else n_pass++;
        rd_ready = 1'b0;
    endtask

    task automatic test_ping_pong();
        logic [DW-1:0] exp_word;
        rd_ready = 1'b0;
        for (int i = 0; i < 2 * PW; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i < PW) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - PW);
            tick();
        end
        wr_valid = 1'b1;
        wr_data  = 16'hC000;
        #1;
        n_total++;
        if (full_banks !== 2'd2 || wr_ready !== 1'b0)
            $display("FAIL pingpong_full: full=%0d wr_ready=%b want 2/0", full_banks, wr_ready);
        else n_pass++;
        repeat (3) tick();
        n_total++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 16'hA000)
            $display("FAIL pingpong_stalled: wr_ready=%b rd_valid=%b data=%h want 0/1/a000", wr_ready, rd_valid, rd_data);
        else n_pass++;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 2 * PW; i++) begin
            exp_word = (i < PW) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - PW);
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== exp_word || rd_last !== (i % PW == PW - 1) || rd_len !== 4'd8)
                $display("FAIL pingpong_word[%0d]: valid=%b data=%h last=%b len=%0d want 1/%h/%b/8",
                         i, rd_valid, rd_data, rd_last, rd_len, exp_word, (i % PW == PW - 1));
            else n_pass++;
            tick();
            if (i == PW - 1) begin
                n_total++;
                if (wr_ready !== 1'b1 || full_banks !== 2'd1)
                    $display("FAIL pingpong_bank_freed: wr_ready=%b full=%0d want 1/1", wr_ready, full_banks);
                else n_pass++;
            end
        end
        n_total++;
        if (empty !== 1'b1 || rd_valid !== 1'b0) $display("FAIL pingpong_done: empty=%b rd_valid=%b want 1/0", empty, rd_valid); else n_pass++;
        rd_ready = 1'b0;
    endtask

    task automatic test_short_commit();
        rd_ready  = 1'b1;
        wr_commit = 1'b1;
        repeat (2) tick();
        wr_commit = 1'b0;
        repeat (3) tick();
        n_total++;
        if (full_banks !== 2'd0 || empty !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL commit_on_free: full=%0d empty=%b rd_valid=%b want 0/1/0", full_banks, empty, rd_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            wr_valid  = 1'b1;
            wr_data   = 16'h3000 + 16'(i);
            wr_commit = (i == 2);
            tick();
        end
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        n_total++;
        if (full_banks !== 2'd1 || rd_valid !== 1'b0) $display("FAIL short_commit_count: full=%0d rd_valid=%b want 1/0", full_banks, rd_valid); else n_pass++;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h3000 + 16'(i) || rd_last !== (i == 2) || rd_len !== 4'd3)
                $display("FAIL short_word[%0d]: valid=%b data=%h last=%b len=%0d want 1/%h/%b/3",
                         i, rd_valid, rd_data, rd_last, rd_len, 16'h3000 + 16'(i), (i == 2));
            else n_pass++;
            tick();
        end
        n_total++;
        if (empty !== 1'b1 || full_banks !== 2'd0 || rd_valid !== 1'b0)
            $display("FAIL short_done: empty=%b full=%0d rd_valid=%b want 1/0/0", empty, full_banks, rd_valid);
        else n_pass++;
        rd_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int unsigned   plen [4];
        logic [DW-1:0] pdata [4][PW];
        logic [DW-1:0] exp_data [$];
        logic          exp_last [$];
        int unsigned   exp_len  [$];
        int            p = 0, w = 0, cycles = 0, got = 0, total = 0;
        logic          prev_stall = 1'b0, prev_last = 1'b0;
        logic [DW-1:0] prev_data = '0;
        for (int i = 0; i < 4; i++) begin
            plen[i] = (i % 2 == 0) ? PW : $urandom_range(1, PW - 1);
            total += int'(plen[i]);
            for (int j = 0; j < PW; j++) pdata[i][j] = DW'($urandom);
        end
        while ((p < 4 || got < total) && cycles < 3000) begin
            if (prev_stall) begin
                n_total++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last)
                    $display("FAIL bp_stall_stable: valid=%b data=%h last=%b want 1/%h/%b", rd_valid, rd_data, rd_last, prev_data, prev_last);
                else n_pass++;
            end
            if (p < 4) begin
                wr_valid  = ($urandom_range(0, 3) != 0);
                wr_data   = pdata[p][w];
                wr_commit = wr_valid && (w == int'(plen[p]) - 1) && (plen[p] < PW);
            end else begin
                wr_valid  = 1'b0;
                wr_commit = 1'b0;
            end
            rd_ready = 1'($urandom_range(0, 1));
            if (wr_valid && wr_ready) begin
                w++;
                if (w == int'(plen[p])) begin
                    for (int j = 0; j < w; j++) begin
                        exp_data.push_back(pdata[p][j]);
                        exp_last.push_back(j == w - 1);
                        exp_len.push_back(plen[p]);
                    end
                    p++;
                    w = 0;
                end
            end
            if (rd_valid && rd_ready) begin
                n_total++;
                if (exp_data.size() == 0) begin
                    $display("FAIL bp_unexpected_word: data=%h want none", rd_data);
                end else begin
                    if (rd_data !== exp_data[0] || rd_last !== exp_last[0] || rd_len !== 4'(exp_len[0]))
                        $display("FAIL bp_word[%0d]: data=%h last=%b len=%0d want %h/%b/%0d",
                                 got, rd_data, rd_last, rd_len, exp_data[0], exp_last[0], exp_len[0]);
                    else n_pass++;
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                    void'(exp_len.pop_front());
                end
                got++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
            tick();
            cycles++;
        end
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        rd_ready  = 1'b1;
        repeat (4) tick();
        n_total++;
        if (got != total || p != 4 || rd_valid !== 1'b0 || empty !== 1'b1)
            $display("FAIL bp_complete: words=%0d pages=%0d rd_valid=%b empty=%b want %0d/4/0/1", got, p, rd_valid, empty, total);
        else n_pass++;
        rd_ready = 1'b0;
    endtask

    task automatic test_single_bank();
        int unsigned   plen [3];
        logic [DW-1:0] pdata [3][PW];
        logic [DW-1:0] exp_data [$];
        logic          exp_last [$];
        int            p = 0, w = 0, cycles = 0, got = 0, total = 0;
        logic          commit_ev, drain_ev;

        b_rd_ready = 1'b0;
        for (int i = 0; i < PW; i++) begin
            b_wr_valid = 1'b1;
            b_wr_data  = 16'h7000 + 16'(i);
            tick();
        end
        b_wr_valid = 1'b1;
        b_wr_data  = 16'hDEAD;
        #1;
        n_total++;
        if (b_wr_ready !== 1'b0 || b_full_banks !== 1'b1)
            $display("FAIL one_after_commit: wr_ready=%b full=%0d want 0/1", b_wr_ready, b_full_banks);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (b_wr_ready !== 1'b0) $display("FAIL one_hold_ready: wr_ready=%b want 0", b_wr_ready); else n_pass++;
        b_wr_valid = 1'b0;
        b_rd_ready = 1'b1;
        for (int i = 0; i < PW; i++) begin
            n_total++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h7000 + 16'(i) || b_rd_last !== (i == PW - 1) ||
                (i < PW - 1 && b_wr_ready !== 1'b0))
                $display("FAIL one_drain[%0d]: valid=%b data=%h last=%b wr_ready=%b want 1/%h/%b/0",
                         i, b_rd_valid, b_rd_data, b_rd_last, b_wr_ready, 16'h7000 + 16'(i), (i == PW - 1));
            else n_pass++;
            tick();
        end
        n_total++;
        if (b_wr_ready !== 1'b1 || b_full_banks !== 1'b0 || b_empty !== 1'b1)
            $display("FAIL one_freed: wr_ready=%b full=%0d empty=%b want 1/0/1", b_wr_ready, b_full_banks, b_empty);
        else n_pass++;

        for (int i = 0; i < 3; i++) begin
            plen[i] = $urandom_range(1, PW);
            total += int'(plen[i]);
            for (int j = 0; j < PW; j++) pdata[i][j] = DW'($urandom);
        end
        while ((p < 3 || got < total) && cycles < 3000) begin
            if (p < 3) begin
                b_wr_valid  = ($urandom_range(0, 3) != 0);
                b_wr_data   = pdata[p][w];
                b_wr_commit = b_wr_valid && (w == int'(plen[p]) - 1) && (plen[p] < PW);
            end else begin
                b_wr_valid  = 1'b0;
                b_wr_commit = 1'b0;
            end
            b_rd_ready = 1'($urandom_range(0, 1));
            commit_ev = 1'b0;
            drain_ev  = b_rd_valid && b_rd_ready && b_rd_last;
            if (b_wr_valid && b_wr_ready) begin
                w++;
                if (w == int'(plen[p])) begin
                    commit_ev = 1'b1;
                    for (int j = 0; j < w; j++) begin
                        exp_data.push_back(pdata[p][j]);
                        exp_last.push_back(j == w - 1);
                    end
                    p++;
                    w = 0;
                end
            end
            if (commit_ev || drain_ev) begin
                n_total++;
                if (commit_ev && drain_ev) $display("FAIL one_commit_and_drain: both events in one cycle, want exclusive");
                else n_pass++;
            end
            if (b_rd_valid && b_rd_ready) begin
                n_total++;
                if (exp_data.size() == 0) begin
                    $display("FAIL one_unexpected_word: data=%h want none", b_rd_data);
                end else begin
                    if (b_rd_data !== exp_data[0] || b_rd_last !== exp_last[0] || b_rd_len === 4'd0)
                        $display("FAIL one_word[%0d]: data=%h last=%b len=%0d want %h/%b/nonzero",
                                 got, b_rd_data, b_rd_last, b_rd_len, exp_data[0], exp_last[0]);
                    else n_pass++;
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
                got++;
            end
            tick();
            cycles++;
        end
        b_wr_valid  = 1'b0;
        b_wr_commit = 1'b0;
        b_rd_ready  = 1'b1;
        repeat (4) tick();
        n_total++;
        if (got != total || p != 3 || b_rd_valid !== 1'b0 || b_empty !== 1'b1)
            $display("FAIL one_complete: words=%0d pages=%0d rd_valid=%b empty=%b want %0d/3/0/1", got, p, b_rd_valid, b_empty, total);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_data     = '0;
        wr_commit   = 1'b0;
        rd_ready    = 1'b0;
        b_wr_valid  = 1'b0;
        b_wr_data   = '0;
        b_wr_commit = 1'b0;
        b_rd_ready  = 1'b0;
        test_reset();
        test_single_page();
        test_ping_pong();
        test_short_commit();
        test_back_pressure();
        test_single_bank();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
